// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   regfile_logsize : register index width
//   md_state_t      : mul/div freeze FSM states
//   ex_rec_t        : EX stage record {wr, rd, load, md}
//   wb_rec_t        : EX/MEM and MEM/WB records {wr, rd}
package hazard_ctrl_pkg;

  localparam int unsigned regfile_logsize = 5;

  typedef enum logic [0:0] {MD_IDLE, MD_BUSY} md_state_t;

  typedef struct packed {
    logic                       wr;
    logic [regfile_logsize-1:0] rd;
    logic                       load;
    logic                       md;
  } ex_rec_t;

  typedef struct packed {
    logic                       wr;
    logic [regfile_logsize-1:0] rd;
  } wb_rec_t;

  // Project an EX record onto the fields carried by the later stages.
  function automatic wb_rec_t ex_to_wb(input ex_rec_t ex);
    wb_rec_t wb;
    wb.wr = ex.wr;
    wb.rd = ex.rd;
    return wb;
  endfunction

endpackage

// File: rtl/md_stall_fsm.sv
// Mul/div freeze sequencer. Keeps a mul/div in EX for exactly MD_LAT cycles.
//   clk    : core clock
//   rst_n  : asynchronous active-low reset
//   flush  : abort any mul/div in progress
//   ex_md  : EX holds a mul/div
//   freeze : hold EX and front end this cycle (combinational from state and ex_md)
module md_stall_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic ex_md,
  output logic freeze
);

  localparam int unsigned CntW = $clog2(MD_LAT);
  // First freeze cycle happens in MD_IDLE and the release cycle at cnt==0,
  // so the counter only spans the MD_LAT-2 cycles in between.
  localparam logic [CntW-1:0] CntLoad = CntW'(MD_LAT - 2);

  md_state_t       state_q;
  logic [CntW-1:0] cnt_q;

  always_comb begin
    freeze = 1'b0;
    if (state_q == MD_IDLE) freeze = ex_md;
    else                    freeze = (cnt_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (ex_md) begin
            state_q <= MD_BUSY;
            cnt_q   <= CntLoad;
          end
        end
        MD_BUSY: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - 1'b1;
          else             state_q <= MD_IDLE;
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller between decode and the forwarding unit.
// Tracks destination info for EX, EX/MEM (1d) and MEM/WB (2d), detects load-use
// hazards and freezes the front end while a mul/div occupies EX.
// Build option: define RV_MULDIV_STALL_EN to enable the mul/div freeze; without it
// id_is_md is ignored, md_busy is 0 and MD_LAT is unused.
// RF_LOGSIZE must equal hazard_ctrl_pkg::regfile_logsize.
//   Inputs : clk, rst_n (async, active-low), id_valid, id_rs1/id_rs2, id_rs1_used/
//            id_rs2_used, id_rd, id_regwr, id_is_load, id_is_md, flush
//   Outputs: stall_if_id, bubble_ex, md_busy, RegWrs_1d/RegW_1d (EX/MEM),
//            RegWrs_2d/RegW_2d (MEM/WB)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT     = 4,
  parameter int unsigned RF_LOGSIZE = regfile_logsize
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [RF_LOGSIZE-1:0] id_rs1,
  input  logic [RF_LOGSIZE-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [RF_LOGSIZE-1:0] id_rd,
  input  logic                  id_regwr,
  input  logic                  id_is_load,
  input  logic                  id_is_md,
  input  logic                  flush,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  md_busy,
  output logic                  RegWrs_1d,
  output logic [RF_LOGSIZE-1:0] RegW_1d,
  output logic                  RegWrs_2d,
  output logic [RF_LOGSIZE-1:0] RegW_2d
);

  ex_rec_t id_rec;
  ex_rec_t ex_q, ex_d;
  wb_rec_t w1_q, w1_d;
  wb_rec_t w2_q, w2_d;
  logic    load_use;
  logic    freeze;

  always_comb begin
    id_rec = '0;
    if (id_valid) begin
      id_rec.wr   = id_regwr;
      id_rec.rd   = id_rd;
      id_rec.load = id_is_load;
`ifdef RV_MULDIV_STALL_EN
      id_rec.md   = id_is_md;
`endif
    end
  end

  // Writes to x0 and unused source fields never create a hazard.
  assign load_use = ex_q.load && ex_q.wr && (ex_q.rd != '0) && id_valid &&
                    ((id_rs1_used && (id_rs1 == ex_q.rd)) ||
                     (id_rs2_used && (id_rs2 == ex_q.rd)));

`ifdef RV_MULDIV_STALL_EN
  md_stall_fsm #(
    .MD_LAT (MD_LAT)
  ) u_md_stall_fsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .ex_md  (ex_q.md),
    .freeze (freeze)
  );
`else
  localparam int unsigned unused_md_lat = MD_LAT;
  logic unused_md;
  assign unused_md = id_is_md ^ ex_q.md;
  assign freeze    = 1'b0;
`endif

  // Priority: flush > mul/div freeze > load-use.
  assign stall_if_id = !flush && (freeze || load_use);
  assign bubble_ex   = flush || (!freeze && load_use);
  assign md_busy     = !flush && freeze;

  always_comb begin
    ex_d = id_rec;
    w1_d = ex_to_wb(ex_q);
    w2_d = w1_q;
    if (flush) begin
      // The EX occupant is squashed, including an aborted mul/div.
      ex_d = '0;
      w1_d = '0;
    end else if (freeze) begin
      ex_d = ex_q;
      w1_d = '0;
    end else if (load_use) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      w1_q <= '0;
      w2_q <= '0;
    end else begin
      ex_q <= ex_d;
      w1_q <= w1_d;
      w2_q <= w2_d;
    end
  end

  assign RegWrs_1d = w1_q.wr;
  assign RegW_1d   = w1_q.rd;
  assign RegWrs_2d = w2_q.wr;
  assign RegW_2d   = w2_q.rd;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each stimulus cycle pushes the expected output
// vector {stall, bubble, md_busy, wr1, rd1, wr2, rd2}; a monitor pops and compares
// on every falling edge.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_regwr, id_is_load, id_is_md, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_if_id, bubble_ex, md_busy, RegWrs_1d, RegWrs_2d;
  logic [4:0] RegW_1d, RegW_2d;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MD_LAT     (4),
    .RF_LOGSIZE (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_regwr    (id_regwr),
    .id_is_load  (id_is_load),
    .id_is_md    (id_is_md),
    .flush       (flush),
    .stall_if_id (stall_if_id),
    .bubble_ex   (bubble_ex),
    .md_busy     (md_busy),
    .RegWrs_1d   (RegWrs_1d),
    .RegW_1d     (RegW_1d),
    .RegWrs_2d   (RegWrs_2d),
    .RegW_2d     (RegW_2d)
  );

  typedef struct {
    string       name;
    logic [14:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [14:0] got;

  assign got = {stall_if_id, bubble_ex, md_busy, RegWrs_1d, RegW_1d, RegWrs_2d, RegW_2d};

  function automatic logic [14:0] E(input logic s, input logic b, input logic m,
                                    input logic w1, input int r1, input logic w2,
                                    input int r2);
    return {s, b, m, w1, 5'(r1), w2, 5'(r2)};
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got s/b/m=%b%b%b w1=%b rd1=%0d w2=%b rd2=%0d, expected %b%b%b %b %0d %b %0d",
                   e.name, got[14], got[13], got[12], got[11], got[10:6], got[5], got[4:0],
                   e.exp[14], e.exp[13], e.exp[12], e.exp[11], e.exp[10:6], e.exp[5],
                   e.exp[4:0]);
        end
      end
    end
  end

  task automatic nop();
    id_valid = 0; id_rd = 0; id_regwr = 0; id_is_load = 0; id_is_md = 0;
    id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
  endtask

  task automatic set_id(input int rd, input logic wr, input logic ld, input logic md,
                        input int rs1, input logic u1, input int rs2, input logic u2);
    id_valid = 1; id_rd = 5'(rd); id_regwr = wr; id_is_load = ld; id_is_md = md;
    id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
  endtask

  // Inputs for this cycle are already applied; queue the expectation, advance.
  task automatic step(input string nm, input logic [14:0] exp);
    exp_t e;
    e.name = nm;
    e.exp  = exp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst_n = 0;
    flush = 0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    step("reset_state", E(0,0,0, 0,0, 0,0));
    rst_n = 1;

    // Load-use on lw x5 followed by add rs1=x5
    set_id(5, 1, 1, 0, 0, 0, 0, 0);  step("lu_c0", E(0,0,0, 0,0, 0,0));
    set_id(6, 1, 0, 0, 5, 1, 0, 0);  step("lu_c1", E(1,1,0, 0,0, 0,0));
                                      step("lu_c2", E(0,0,0, 1,5, 0,0));
    nop();                            step("lu_c3", E(0,0,0, 0,0, 1,5));
                                      step("lu_c4", E(0,0,0, 1,6, 0,0));
                                      step("lu_c5", E(0,0,0, 0,0, 1,6));
                                      step("lu_c6", E(0,0,0, 0,0, 0,0));

    // Non-hazards: lw x0 then use of x0; lw x5 then unused rs2=x5
    set_id(0, 1, 1, 0, 0, 0, 0, 0);  step("nh_c0", E(0,0,0, 0,0, 0,0));
    set_id(8, 1, 0, 0, 0, 1, 0, 1);  step("nh_x0_use", E(0,0,0, 0,0, 0,0));
    set_id(5, 1, 1, 0, 0, 0, 0, 0);  step("nh_c2", E(0,0,0, 1,0, 0,0));
    set_id(9, 1, 0, 0, 3, 1, 5, 0);  step("nh_rs2_unused", E(0,0,0, 1,8, 1,0));
    nop();                            step("nh_c4", E(0,0,0, 1,5, 1,8));
                                      step("nh_c5", E(0,0,0, 1,9, 1,5));
                                      step("nh_c6", E(0,0,0, 0,0, 1,9));
                                      step("nh_c7", E(0,0,0, 0,0, 0,0));

    // div x7 followed by a dependent add x10
    set_id(7, 1, 0, 1, 1, 1, 2, 1);  step("md_c0", E(0,0,0, 0,0, 0,0));
    set_id(10, 1, 0, 0, 7, 1, 0, 0);
`ifdef RV_MULDIV_STALL_EN
                                      step("md_c1", E(1,0,1, 0,0, 0,0));
                                      step("md_c2", E(1,0,1, 0,0, 0,0));
                                      step("md_c3", E(1,0,1, 0,0, 0,0));
                                      step("md_c4_release", E(0,0,0, 0,0, 0,0));
    nop();                            step("md_c5", E(0,0,0, 1,7, 0,0));
                                      step("md_c6", E(0,0,0, 1,10, 1,7));
                                      step("md_c7", E(0,0,0, 0,0, 1,10));
                                      step("md_c8", E(0,0,0, 0,0, 0,0));
`else
                                      step("md_off_c1", E(0,0,0, 0,0, 0,0));
    nop();                            step("md_off_c2", E(0,0,0, 1,7, 0,0));
                                      step("md_off_c3", E(0,0,0, 1,10, 1,7));
                                      step("md_off_c4", E(0,0,0, 0,0, 1,10));
                                      step("md_off_c5", E(0,0,0, 0,0, 0,0));
`endif

    // Flush coincident with a load-use condition
    set_id(5, 1, 1, 0, 0, 0, 0, 0);  step("fl_lu_c0", E(0,0,0, 0,0, 0,0));
    set_id(6, 1, 0, 0, 5, 1, 0, 0);
    flush = 1;                        step("fl_lu_c1", E(0,1,0, 0,0, 0,0));
    flush = 0; nop();                 step("fl_lu_c2", E(0,0,0, 0,0, 0,0));
                                      step("fl_lu_c3", E(0,0,0, 0,0, 0,0));

`ifdef RV_MULDIV_STALL_EN
    // Flush at cycle 2 of a mul/div freeze
    set_id(7, 1, 0, 1, 0, 0, 0, 0);  step("fl_md_c0", E(0,0,0, 0,0, 0,0));
    nop();                            step("fl_md_c1", E(1,0,1, 0,0, 0,0));
    flush = 1;                        step("fl_md_c2", E(0,1,0, 0,0, 0,0));
    flush = 0;                        step("fl_md_c3", E(0,0,0, 0,0, 0,0));
                                      step("fl_md_c4", E(0,0,0, 0,0, 0,0));
`endif

    // Reset asserted mid-freeze
    set_id(3, 1, 0, 0, 0, 0, 0, 0);  step("rst_md_pre", E(0,0,0, 0,0, 0,0));
    set_id(7, 1, 0, 1, 0, 0, 0, 0);  step("rst_md_c0", E(0,0,0, 0,0, 0,0));
    nop();
`ifdef RV_MULDIV_STALL_EN
                                      step("rst_md_c1", E(1,0,1, 1,3, 0,0));
`else
                                      step("rst_md_c1", E(0,0,0, 1,3, 0,0));
`endif
    rst_n = 0;                        step("rst_md_c2_async", E(0,0,0, 0,0, 0,0));
                                      step("rst_md_c3", E(0,0,0, 0,0, 0,0));
    rst_n = 1;                        step("rst_md_after", E(0,0,0, 0,0, 0,0));
                                      step("rst_md_after2", E(0,0,0, 0,0, 0,0));

    guard = 0;
    while (sbq.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core, sitting between decode and the forwarding unit. Tracks destination-register info for the EX, EX/MEM and MEM/WB stages and drives the `RegWrs_1d`/`RegW_1d`/`RegWrs_2d`/`RegW_2d` inputs consumed by `forw_unit`. Detects load-use hazards and freezes the front end for multi-cycle mul/div, inserting bubbles so forwarding always sees consistent stage data.

## Interface
- `MD_LAT`, 4: cycles a mul/div occupies EX; legal values are ≥ 2.
- `RF_LOGSIZE`, `` `regfile_logsize `` (5): register index width.

- `clk` in 1: core clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `id_valid` in 1: ID holds a valid instruction.
- `id_rs1`, `id_rs2` in RF_LOGSIZE: ID source indices.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in RF_LOGSIZE: ID destination.
- `id_regwr` in 1: ID writes `rd`.
- `id_is_load` in 1: ID is a load.
- `id_is_md` in 1: ID is mul/div.
- `flush` in 1: taken branch/jump resolved in EX.
- `stall_if_id` out 1: hold PC and the IF/ID register.
- `bubble_ex` out 1: ID/EX loads a NOP.
- `md_busy` out 1: mul/div freeze active.
- `RegWrs_1d` out 1, `RegW_1d` out RF_LOGSIZE: EX/MEM write enable and destination.
- `RegWrs_2d` out 1, `RegW_2d` out RF_LOGSIZE: MEM/WB write enable and destination.

## Operation
- Internal stage records: EX = {wr, rd, load, md}, plus 1d and 2d = {wr, rd}.
- The ID record is gated by `id_valid`. A bubble is all-zero.
- Normal edge: EX←ID record; 1d←EX; 2d←1d.
- Load-use hazard, combinational:
  - EX.load & EX.wr & EX.rd≠0 & id_valid & ((id_rs1_used & id_rs1==EX.rd) | (id_rs2_used & id_rs2==EX.rd)).
  - Response: `stall_if_id`=1, `bubble_ex`=1. EX←bubble; 1d and 2d advance.
- mul/div FSM, states MD_IDLE and MD_BUSY, with counter `cnt` of width $clog2(MD_LAT).
  - MD_IDLE with EX.md=1: freeze. Set cnt←MD_LAT-2 and go to MD_BUSY.
  - MD_BUSY with cnt≠0: freeze and cnt←cnt-1.
  - MD_BUSY with cnt==0: release (no freeze), go to MD_IDLE, normal advance.
  - Freeze means `stall_if_id`=1, `md_busy`=1, `bubble_ex`=0, EX held, 1d←bubble, 2d←1d.
  - The md instruction therefore occupies EX for exactly MD_LAT cycles.
- Priority: `flush` > md freeze > load-use.
  - `flush`: EX←bubble, `bubble_ex`=1, `stall_if_id`=0, FSM→MD_IDLE, cnt←0. This aborts any md in progress.
- An ID instruction depending on a md result gets no extra stall; it forwards from 1d after release.

## Timing
- Stage records, FSM and counter are registered. `stall_if_id`, `bubble_ex` and `md_busy` are combinational from registered state and ID inputs.
- Reset (async, immediate):
  - All records zero, FSM MD_IDLE, cnt 0.
  - Hence every output reads 0.
  - Reset mid-freeze aborts the md.
- Load-use costs exactly 1 bubble. md costs MD_LAT-1 stall cycles.
- No stall is ever raised for rd=x0 or for unused sources.

## Configuration
- `RV_MULDIV_STALL_EN` defined: FSM and counter present, behaviour as above.
- `RV_MULDIV_STALL_EN` undefined:
  - `id_is_md` is ignored and EX.md is held at 0.
  - `md_busy` is tied to 0. No FSM or counter is instantiated.
  - `MD_LAT` is unused.

## Structure
- Shared constants package holds:
  - `regfile_logsize`;
  - `md_state_t` enum {MD_IDLE, MD_BUSY};
  - `ex_rec_t` struct {wr, rd, load, md} and `wb_rec_t` struct {wr, rd}.
- One sub-module, `md_stall_fsm`: FSM plus counter.
  - Inputs: `clk`, `rst_n`, `flush`, `ex_md`.
  - Output: `freeze`.
  - Instantiated only under `RV_MULDIV_STALL_EN`.

## Test plan
- Reset: drive `rst_n`=0 mid-freeze (MD_LAT=4, cycle 2) → all outputs 0 in the same cycle. After release, `md_busy`=0 until a new md arrives.
- Load-use on `lw x5`:
  - Stimulus: lw x5 in ID at c0, then add rs1=5 used at c1.
  - c1: `stall_if_id`=1, `bubble_ex`=1.
  - c2: no stall; RegWrs_1d=1, RegW_1d=5.
  - c3: RegWrs_1d=0, RegWrs_2d=1, RegW_2d=5.
- Non-hazards: lw x0 followed by use of x0, or lw x5 followed by an instruction with rs2=5 and `id_rs2_used`=0 → `stall_if_id`=0 throughout.
- mul/div, MD_LAT=4: div x7 enters EX at c1.
  - c1–c3: `stall_if_id`=1 and `md_busy`=1.
  - c4: released.
  - RegWrs_1d=0 at c2–c4; RegWrs_1d=1 with RegW_1d=7 at c5.
- Flush priority: `flush`=1 coincident with a load-use condition, and separately at c2 of a md freeze → `stall_if_id`=0, `bubble_ex`=1, `md_busy`=0 on the next cycle, RegWrs_1d=0 on the next edge.
- Macro off: `id_is_md`=1 for div x7 → no stall; RegW_1d=7 one cycle after EX entry.
